// File: rtl/htbpa_seq.sv
// ---------------------------------------------------------------------------
// htbpa_seq -- microcoded issue sequencer for the pairing arithmetic datapath.
//
// Fetches 64-bit microinstructions from a 1-cycle-latency instruction memory.
// It drives the operand-RAM read addresses and the preadder / cmul / postadder
// mode fields. A PIPE_LAT-deep tag line re-times each write-back address so
// that we/waddr line up with the postadder result of the same instruction.
//
// Ports
//   clk                       rising-edge clock
//   rstn                      synchronous active-low reset
//   start                     one-cycle pulse, runs the program from pc=0
//   busy                      high from the cycle after start until done
//   done                      one-cycle pulse once END retired and drained
//   imem_addr / imem_dout     instruction fetch (dout valid one cycle later)
//   raddr0, raddr1            RAM0 / RAM1 read addresses
//   mode1, mode2              preadder modes
//   cmul_mode                 cmul mode
//   pmode1..pmode3            postadder modes
//   outsel, addr2, addr3      postadder selects
//   waddr, we                 write port, aligned with postadder dout
// ---------------------------------------------------------------------------
module htbpa_seq #(
    parameter int PIPE_LAT = 12,
    parameter int AW       = 9,
    parameter int PCW      = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [PCW-1:0] imem_addr,
    input  logic [63:0]    imem_dout,
    output logic [AW-1:0]  raddr0,
    output logic [AW-1:0]  raddr1,
    output logic [2:0]     mode1,
    output logic [2:0]     mode2,
    output logic [2:0]     cmul_mode,
    output logic [2:0]     pmode1,
    output logic [2:0]     pmode2,
    output logic [2:0]     pmode3,
    output logic [1:0]     outsel,
    output logic [1:0]     addr2,
    output logic [1:0]     addr3,
    output logic [AW-1:0]  waddr,
    output logic           we
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_EXEC = 3'b001;
    localparam logic [2:0] OP_SYNC = 3'b010;
    localparam logic [2:0] OP_END  = 3'b111;

    localparam logic [PCW-1:0] PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};
    localparam logic [PCW:0]   INF_ONE = {{PCW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;

    logic [PCW-1:0] pc_r;
    logic [PCW-1:0] imem_addr_r;
    logic           fetch_v_r;     // imem_addr_r holds a live fetch this cycle
    logic           dout_v_r;      // imem_dout holds the word of a live fetch
    logic           busy_r;
    logic           done_r;

    logic [PCW:0]   inflight_r;
    logic [PCW:0]   inflight_nxt_s;

    logic           decode_s;
    logic [2:0]     op_s;
    logic           is_exec_s;
    logic           is_sync_s;
    logic           is_end_s;
    logic           inc_s;
    logic [AW:0]    tag_s;

    logic [AW:0]    dl_r [PIPE_LAT];
    logic           we_r;
    logic [AW-1:0]  waddr_r;

    logic [AW-1:0]  raddr0_s, raddr1_s;
    logic [2:0]     mode1_s, mode2_s, cmul_mode_s;
    logic [2:0]     pmode1_s, pmode2_s, pmode3_s;
    logic [1:0]     outsel_s, addr2_s, addr3_s;

    logic [AW-1:0]  raddr0_r, raddr1_r;
    logic [2:0]     mode1_r, mode2_r, cmul_mode_r;
    logic [2:0]     pmode1_r, pmode2_r, pmode3_r;
    logic [1:0]     outsel_r, addr2_r, addr3_r;

    // Reserved instruction bits carry no meaning.
    logic           unused_rsv_s;
    assign unused_rsv_s = ^imem_dout[8:0];

    // Instruction decode: only a live word seen in RUN is acted upon.
    always_comb begin
        decode_s  = (state_r == ST_RUN) && dout_v_r;
        op_s      = imem_dout[63:61];
        is_exec_s = 1'b0;
        is_sync_s = 1'b0;
        is_end_s  = 1'b0;
        if (decode_s) begin
            case (op_s)
                OP_EXEC: is_exec_s = 1'b1;
                OP_SYNC: is_sync_s = 1'b1;
                OP_END:  is_end_s  = 1'b1;
                OP_NOP:  is_exec_s = 1'b0;
                default: is_exec_s = 1'b0;
            endcase
        end else begin
            is_exec_s = 1'b0;
        end
        inc_s = is_exec_s && imem_dout[9];
    end

    // Control fields for the next cycle; anything but EXEC issues zeros.
    always_comb begin
        raddr0_s    = {AW{1'b0}};
        raddr1_s    = {AW{1'b0}};
        mode1_s     = 3'd0;
        mode2_s     = 3'd0;
        cmul_mode_s = 3'd0;
        pmode1_s    = 3'd0;
        pmode2_s    = 3'd0;
        pmode3_s    = 3'd0;
        outsel_s    = 2'd0;
        addr2_s     = 2'd0;
        addr3_s     = 2'd0;
        tag_s       = {(AW+1){1'b0}};
        if (is_exec_s) begin
            raddr0_s    = AW'(imem_dout[60:52]);
            raddr1_s    = AW'(imem_dout[51:43]);
            mode1_s     = imem_dout[33:31];
            mode2_s     = imem_dout[30:28];
            cmul_mode_s = imem_dout[27:25];
            pmode1_s    = imem_dout[24:22];
            pmode2_s    = imem_dout[21:19];
            pmode3_s    = imem_dout[18:16];
            outsel_s    = imem_dout[15:14];
            addr2_s     = imem_dout[13:12];
            addr3_s     = imem_dout[11:10];
            // waddr is forced to 0 in slots without a write
            if (imem_dout[9]) begin
                tag_s = {1'b1, AW'(imem_dout[42:34])};
            end else begin
                tag_s = {(AW+1){1'b0}};
            end
        end else begin
            tag_s = {(AW+1){1'b0}};
        end
    end

    // In-flight write counter update: issue adds one, retire removes one.
    always_comb begin
        case ({inc_s, we_r})
            2'b10:   inflight_nxt_s = inflight_r + INF_ONE;
            2'b01:   inflight_nxt_s = inflight_r - INF_ONE;
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Next-state logic of the sequencer FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (is_sync_s) begin
                    state_nxt_s = ST_SYNC;
                end else if (is_end_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SYNC: begin
                if (inflight_r == {(PCW+1){1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            // Looking at the next count lets done fire the cycle after the last write.
            ST_DRAIN: begin
                if (inflight_nxt_s == {(PCW+1){1'b0}}) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus the status outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_SYNC) ||
                       (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Fetch engine: pc always points at the next address to fetch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_r        <= {PCW{1'b0}};
            imem_addr_r <= {PCW{1'b0}};
            fetch_v_r   <= 1'b0;
            dout_v_r    <= 1'b0;
        end else begin
            dout_v_r <= fetch_v_r;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        imem_addr_r <= {PCW{1'b0}};
                        pc_r        <= PC_ONE;
                        fetch_v_r   <= 1'b1;
                    end else begin
                        fetch_v_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (is_sync_s) begin
                        // pc is two ahead of the SYNC word; resume right after it
                        pc_r      <= pc_r - PC_ONE;
                        fetch_v_r <= 1'b0;
                    end else if (is_end_s) begin
                        fetch_v_r <= 1'b0;
                    end else begin
                        imem_addr_r <= pc_r;
                        pc_r        <= pc_r + PC_ONE;
                        fetch_v_r   <= 1'b1;
                    end
                end
                default: fetch_v_r <= 1'b0;
            endcase
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            raddr0_r    <= {AW{1'b0}};
            raddr1_r    <= {AW{1'b0}};
            mode1_r     <= 3'd0;
            mode2_r     <= 3'd0;
            cmul_mode_r <= 3'd0;
            pmode1_r    <= 3'd0;
            pmode2_r    <= 3'd0;
            pmode3_r    <= 3'd0;
            outsel_r    <= 2'd0;
            addr2_r     <= 2'd0;
            addr3_r     <= 2'd0;
        end else begin
            raddr0_r    <= raddr0_s;
            raddr1_r    <= raddr1_s;
            mode1_r     <= mode1_s;
            mode2_r     <= mode2_s;
            cmul_mode_r <= cmul_mode_s;
            pmode1_r    <= pmode1_s;
            pmode2_r    <= pmode2_s;
            pmode3_r    <= pmode3_s;
            outsel_r    <= outsel_s;
            addr2_r     <= addr2_s;
            addr3_r     <= addr3_s;
        end
    end

    // Write-tag delay line; the final register stage makes we land PIPE_LAT
    // cycles after the control outputs of the same instruction.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_r[i] <= {(AW+1){1'b0}};
            end
            we_r    <= 1'b0;
            waddr_r <= {AW{1'b0}};
        end else begin
            dl_r[0] <= tag_s;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_r[i] <= dl_r[i-1];
            end
            we_r    <= dl_r[PIPE_LAT-1][AW];
            waddr_r <= dl_r[PIPE_LAT-1][AW-1:0];
        end
    end

    // In-flight write counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            inflight_r <= {(PCW+1){1'b0}};
        end else begin
            inflight_r <= inflight_nxt_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign imem_addr = imem_addr_r;
    assign raddr0    = raddr0_r;
    assign raddr1    = raddr1_r;
    assign mode1     = mode1_r;
    assign mode2     = mode2_r;
    assign cmul_mode = cmul_mode_r;
    assign pmode1    = pmode1_r;
    assign pmode2    = pmode2_r;
    assign pmode3    = pmode3_r;
    assign outsel    = outsel_r;
    assign addr2     = addr2_r;
    assign addr3     = addr3_r;
    assign waddr     = waddr_r;
    assign we        = we_r;

endmodule

// File: tb/tb_htbpa_seq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for htbpa_seq. Cycle k of a run is the k-th cycle after
// the one in which start is high (start cycle = cycle 0). Outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_htbpa_seq;
    localparam int PIPE_LAT = 12;
    localparam int AW       = 9;
    localparam int PCW      = 8;
    localparam int TRN      = 64;

    logic           clk = 1'b0;
    logic           rstn;
    logic           start;
    logic           busy, done;
    logic [PCW-1:0] imem_addr;
    logic [63:0]    imem_dout;
    logic [AW-1:0]  raddr0, raddr1, waddr;
    logic [2:0]     mode1, mode2, cmul_mode, pmode1, pmode2, pmode3;
    logic [1:0]     outsel, addr2, addr3;
    logic           we;

    htbpa_seq #(.PIPE_LAT(PIPE_LAT), .AW(AW), .PCW(PCW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
        .imem_addr(imem_addr), .imem_dout(imem_dout),
        .raddr0(raddr0), .raddr1(raddr1), .mode1(mode1), .mode2(mode2),
        .cmul_mode(cmul_mode), .pmode1(pmode1), .pmode2(pmode2), .pmode3(pmode3),
        .outsel(outsel), .addr2(addr2), .addr3(addr3), .waddr(waddr), .we(we)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency instruction memory
    logic [63:0] mem [256];
    always @(posedge clk) imem_dout <= mem[imem_addr];

    logic [41:0] ctl_w;
    assign ctl_w = {raddr0, raddr1, mode1, mode2, cmul_mode, pmode1, pmode2, pmode3,
                    outsel, addr2, addr3};

    int n_checks = 0;
    int n_errors = 0;

    logic [41:0]   tr_ctl   [TRN];
    logic          tr_we    [TRN];
    logic [AW-1:0] tr_waddr [TRN];
    logic          tr_done  [TRN];
    logic          tr_busy  [TRN];
    int            tr_infl  [TRN];

    typedef struct {
        logic [2:0]  op;
        logic [8:0]  ra0, ra1, wa;
        logic [2:0]  m1, m2, cm, p1, p2, p3;
        logic [1:0]  os, a2, a3;
        logic        wen;
        logic [8:0]  rsv;
        logic [41:0] e_ctl;
        logic        e_we;
        logic [8:0]  e_waddr;
        int          e_done;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [2:0] op, input logic [8:0] ra0,
            input logic [8:0] ra1, input logic [8:0] wa, input logic [2:0] m1,
            input logic [2:0] m2, input logic [2:0] cm, input logic [2:0] p1,
            input logic [2:0] p2, input logic [2:0] p3, input logic [1:0] os,
            input logic [1:0] a2, input logic [1:0] a3, input logic wen,
            input logic [8:0] rsv);
        return {op, ra0, ra1, wa, m1, m2, cm, p1, p2, p3, os, a2, a3, wen, rsv};
    endfunction

    function automatic logic [63:0] ex(input logic [8:0] ra0, input logic [8:0] ra1,
            input logic [8:0] wa, input logic wen);
        return mk(3'd1, ra0, ra1, wa, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                  2'd0, 2'd0, 2'd0, wen, 9'd0);
    endfunction

    localparam logic [63:0] SYNC_W = {3'b010, 61'd0};
    localparam logic [63:0] END_W  = {3'b111, 61'd0};

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;
    endtask

    // Pulse start (cycle 0), record n cycles; optional extra start pulse.
    task automatic run_capture(input int n, input int restart_at);
        @(posedge clk); #1 start = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_ctl[k]   = ctl_w;
            tr_we[k]    = we;
            tr_waddr[k] = waddr;
            tr_done[k]  = done;
            tr_busy[k]  = busy;
            tr_infl[k]  = int'(dut.inflight_r);
            @(posedge clk); #1;
            start = (k + 1 == restart_at);
        end
        start = 1'b0;
    endtask

    function automatic int find_done(input int n);
        for (int k = 0; k < n; k++) if (tr_done[k]) return k;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (tr_done[k]) c++;
        return c;
    endfunction

    function automatic int count_we(input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (tr_we[k]) c++;
        return c;
    endfunction

    initial begin
        vt[0] = '{3'd1, 9'd5, 9'd6, 9'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 2'd1, 2'd2, 2'd3,
                  1'b1, 9'd0,
                  {9'd5, 9'd6, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 2'd1, 2'd2, 2'd3},
                  1'b1, 9'd7, 16};
        vt[1] = '{3'd1, 9'd511, 9'd0, 9'd511, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 2'd3, 2'd3, 2'd3,
                  1'b1, 9'h1FF,
                  {9'd511, 9'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 2'd3, 2'd3, 2'd3},
                  1'b1, 9'd511, 16};
        vt[2] = '{3'd1, 9'h0AA, 9'h155, 9'd3, 3'd5, 3'd0, 3'd2, 3'd0, 3'd7, 3'd1, 2'd2, 2'd0, 2'd1,
                  1'b0, 9'd0,
                  {9'h0AA, 9'h155, 3'd5, 3'd0, 3'd2, 3'd0, 3'd7, 3'd1, 2'd2, 2'd0, 2'd1},
                  1'b0, 9'd0, 5};
        vt[3] = '{3'd0, 9'd5, 9'd6, 9'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 2'd1, 2'd2, 2'd3,
                  1'b1, 9'd0, 42'd0, 1'b0, 9'd0, 5};
        vt[4] = '{3'd3, 9'd5, 9'd6, 9'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 2'd1, 2'd2, 2'd3,
                  1'b1, 9'd0, 42'd0, 1'b0, 9'd0, 5};
        vt[5] = '{3'd6, 9'd5, 9'd6, 9'd7, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 2'd1, 2'd2, 2'd3,
                  1'b1, 9'd0, 42'd0, 1'b0, 9'd0, 5};

        // ---------------- reset with start held high ----------------
        rstn  = 1'b0;
        start = 1'b1;
        clear_mem();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_outputs c%0d", i),
                {2'b00, ctl_w, we, waddr, done, busy, imem_addr}, 64'd0);
        end
        @(posedge clk); #1;
        rstn  = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);

        // ---------------- table-driven single-instruction programs ----------------
        for (int r = 0; r < 6; r++) begin
            clear_mem();
            mem[0] = mk(vt[r].op, vt[r].ra0, vt[r].ra1, vt[r].wa, vt[r].m1, vt[r].m2,
                        vt[r].cm, vt[r].p1, vt[r].p2, vt[r].p3, vt[r].os, vt[r].a2,
                        vt[r].a3, vt[r].wen, vt[r].rsv);
            mem[1] = END_W;
            run_capture(24, -1);
            chk($sformatf("row%0d ctl@2", r), 64'(tr_ctl[2]), 64'd0);
            chk($sformatf("row%0d ctl@3", r), 64'(tr_ctl[3]), 64'(vt[r].e_ctl));
            chk($sformatf("row%0d ctl@4", r), 64'(tr_ctl[4]), 64'd0);
            chk($sformatf("row%0d we@15", r), 64'(tr_we[15]), 64'(vt[r].e_we));
            chk($sformatf("row%0d waddr@15", r), 64'(tr_waddr[15]), 64'(vt[r].e_waddr));
            chk($sformatf("row%0d we_count", r), 64'(count_we(24)), 64'(vt[r].e_we));
            chk($sformatf("row%0d done_cycle", r), 64'(find_done(24)), 64'(vt[r].e_done));
            chk($sformatf("row%0d done_count", r), 64'(count_done(24)), 64'd1);
            chk($sformatf("row%0d busy@1", r), 64'(tr_busy[1]), 64'd1);
            chk($sformatf("row%0d busy@done-1", r), 64'(tr_busy[vt[r].e_done-1]), 64'd1);
            chk($sformatf("row%0d busy@done", r), 64'(tr_busy[vt[r].e_done]), 64'd0);
            repeat (3) @(posedge clk);
        end

        // ---------------- four back-to-back EXECs ----------------
        begin
            int mx;
            clear_mem();
            for (int k = 0; k < 4; k++) mem[k] = ex(9'(10 + k), 9'd0, 9'(k + 1), 1'b1);
            mem[4] = END_W;
            run_capture(30, -1);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("b2b raddr0@%0d", 3 + k), 64'(tr_ctl[3+k][41:33]), 64'(10 + k));
                chk($sformatf("b2b we@%0d", 15 + k), 64'(tr_we[15+k]), 64'd1);
                chk($sformatf("b2b waddr@%0d", 15 + k), 64'(tr_waddr[15+k]), 64'(k + 1));
            end
            chk("b2b we_count", 64'(count_we(30)), 64'd4);
            mx = 0;
            for (int k = 0; k < 30; k++) if (tr_infl[k] > mx) mx = tr_infl[k];
            chk("b2b inflight_peak", 64'(mx), 64'd4);
            chk("b2b inflight_end", 64'(tr_infl[29]), 64'd0);
            chk("b2b done_cycle", 64'(find_done(30)), 64'd19);
            repeat (3) @(posedge clk);
        end

        // ---------------- SYNC waits for the write ----------------
        begin
            int first9, nz;
            clear_mem();
            mem[0] = ex(9'd1, 9'd0, 9'd9, 1'b1);
            mem[1] = SYNC_W;
            mem[2] = ex(9'd9, 9'd0, 9'd20, 1'b1);
            mem[3] = END_W;
            run_capture(40, -1);
            chk("sync raddr0@3", 64'(tr_ctl[3][41:33]), 64'd1);
            chk("sync we@15", 64'(tr_we[15]), 64'd1);
            chk("sync waddr@15", 64'(tr_waddr[15]), 64'd9);
            first9 = -1;
            for (int k = 39; k >= 0; k--) if (tr_ctl[k][41:33] == 9'd9) first9 = k;
            chk("sync second_issue_cycle", 64'(first9), 64'd20);
            nz = 0;
            for (int k = 4; k < 20; k++) if (tr_ctl[k] != 42'd0) nz++;
            chk("sync stall_outputs_zero", 64'(nz), 64'd0);
            chk("sync we@32", 64'(tr_we[32]), 64'd1);
            chk("sync waddr@32", 64'(tr_waddr[32]), 64'd20);
            chk("sync we_count", 64'(count_we(40)), 64'd2);
            chk("sync done_cycle", 64'(find_done(40)), 64'd33);
            repeat (3) @(posedge clk);
        end

        // ---------------- reset with writes in flight ----------------
        begin
            int bad;
            clear_mem();
            mem[0] = ex(9'd1, 9'd0, 9'd1, 1'b1);
            mem[1] = ex(9'd2, 9'd0, 9'd2, 1'b1);
            mem[2] = ex(9'd3, 9'd0, 9'd3, 1'b1);
            mem[3] = END_W;
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            repeat (7) @(posedge clk);
            @(negedge clk);
            chk("midrst inflight_before", 64'(dut.inflight_r), 64'd3);
            rstn = 1'b0;
            @(posedge clk);
            @(posedge clk); #1 rstn = 1'b1;
            bad = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (we || busy || done) bad++;
            end
            chk("midrst no_activity_20", 64'(bad), 64'd0);
            chk("midrst inflight_after", 64'(dut.inflight_r), 64'd0);
            run_capture(30, -1);
            chk("midrst rerun raddr0@3", 64'(tr_ctl[3][41:33]), 64'd1);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("midrst rerun waddr@%0d", 15 + k), 64'({tr_we[15+k], tr_waddr[15+k]}),
                    64'({1'b1, 9'(k + 1)}));
            end
            chk("midrst rerun done_cycle", 64'(find_done(30)), 64'd18);
            repeat (3) @(posedge clk);
        end

        // ---------------- start while busy, wen=0 slot ----------------
        clear_mem();
        mem[0] = ex(9'd1, 9'd1, 9'd1, 1'b1);
        mem[1] = ex(9'd2, 9'd2, 9'd5, 1'b0);
        mem[2] = ex(9'd3, 9'd3, 9'd3, 1'b1);
        mem[3] = END_W;
        run_capture(40, 6);
        chk("busystart raddr0@4", 64'(tr_ctl[4][41:33]), 64'd2);
        chk("busystart we@15", 64'({tr_we[15], tr_waddr[15]}), 64'({1'b1, 9'd1}));
        chk("busystart we@16", 64'(tr_we[16]), 64'd0);
        chk("busystart we@17", 64'({tr_we[17], tr_waddr[17]}), 64'({1'b1, 9'd3}));
        chk("busystart we_count", 64'(count_we(40)), 64'd2);
        chk("busystart done_count", 64'(count_done(40)), 64'd1);
        chk("busystart done_cycle", 64'(find_done(40)), 64'd18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/htbpa_seq.md
# htbpa_seq

Microcoded issue sequencer for the pairing arithmetic datapath. It fetches 64-bit instructions from a 1-cycle-latency instruction memory and drives the two operand-RAM read addresses and the mode fields of preadder, cmul and postadder. A PIPE_LAT-deep tag delay line re-times each write-back address so that the RAM write port fires exactly when postadder produces the matching result. It sits directly upstream of the operand RAMs and the preadder→L3touint→QPMM_d0→cmul→postadder chain.

## Interface
- PIPE_LAT, 12: cycles from a registered read address to the corresponding postadder dout; must be ≥ 1.
- AW, 9: RAM address width.
- PCW, 8: program counter width.
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins execution at pc=0
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when END has retired and the pipeline is drained
- imem_addr  out  PCW  instruction address; imem_dout is valid on the following cycle
- imem_dout  in  64  instruction word
- raddr0, raddr1  out  AW  read addresses for RAM0 and RAM1
- mode1, mode2  out  3  preadder modes
- cmul_mode  out  3  cmul mode
- pmode1, pmode2, pmode3  out  3  postadder modes
- outsel, addr2, addr3  out  2  postadder selects
- waddr  out  AW  write address, aligned with postadder dout
- we  out  1  write enable, aligned with postadder dout

## Operation
- Instruction fields: [63:61] op; [60:52] ra0; [51:43] ra1; [42:34] wa; [33:31] mode1; [30:28] mode2; [27:25] cmul_mode; [24:22] pmode1; [21:19] pmode2; [18:16] pmode3; [15:14] outsel; [13:12] addr2; [11:10] addr3; [9] wen; [8:0] reserved.
- Opcodes:
  - 000 NOP: issues zeros on all control outputs.
  - 001 EXEC: registers all fields onto the outputs and pushes {wen, wa} into the delay line.
  - 010 SYNC: stalls until the in-flight count reaches 0.
  - 111 END: stops fetching, drains the pipeline, then pulses done.
  - Any other opcode executes as NOP.
- FSM states: IDLE, RUN, SYNC, DRAIN, DONE.
  - IDLE→RUN on start. pc is set to 0.
  - RUN: fetches pc every cycle and increments pc. Decodes the returned word each cycle.
  - RUN→SYNC on SYNC. The prefetched word is discarded and pc is set to sync_pc+1.
  - SYNC→RUN when inflight==0, with one refetch bubble.
  - RUN→DRAIN on END. The prefetched word is discarded.
  - DRAIN→DONE when inflight==0.
  - DONE→IDLE after one cycle. done=1 only in DONE.
- inflight counter, width PCW+1:
  - +1 when an EXEC with wen=1 is issued.
  - −1 when we=1.
  - Simultaneous +1 and −1 leaves the count unchanged.
- pc wraps from 2^PCW−1 to 0 with no flag.
- start is ignored whenever busy=1.
- Reset (any state, including mid-program):
  - All outputs go to 0 and the state goes to IDLE.
  - The delay line and inflight are cleared, so no write from a pre-reset instruction fires after reset.

## Timing
- start at cycle 0: imem_addr=0 at cycle 1, word 0 decoded at cycle 2, control outputs for word 0 valid at cycle 3.
- Straight-line EXEC stream: one instruction per cycle. The instruction at address k drives the control outputs at cycle 3+k.
- An EXEC whose control outputs appear at cycle c asserts we/waddr at cycle c+PIPE_LAT. Tags without wen produce we=0 in that slot.
- SYNC costs inflight-drain cycles plus a 2-cycle refetch. Control outputs hold 0 during the stall.
- done fires the cycle after inflight reaches 0 in DRAIN. busy falls together with done.
- Non-EXEC cycles drive raddr and modes to 0 (not hold).

## Test plan
- Reset: hold rstn=0 for 3 cycles with start=1 → all outputs 0, busy=0, no we.
- Program EXEC(ra0=5, ra1=6, wa=7, wen=1), END with PIPE_LAT=12, start at cycle 0 → raddr0=5 and raddr1=6 at cycle 3, we=1 with waddr=7 at cycle 15, done at cycle 16.
- Four back-to-back EXECs with wa=1..4 → we high for 4 consecutive cycles with waddr 1,2,3,4. inflight peaks at 4 and returns to 0.
- EXEC(wa=9, wen=1), SYNC, EXEC(ra0=9) → the second EXEC's raddr0=9 appears strictly after the cycle where we=1, waddr=9.
- Assert rstn=0 mid-stream with 3 writes in flight → no we for 20 cycles after release. A new start runs the program from pc=0.
- start pulse while busy, plus EXEC with wen=0 → no restart, no we in that slot, done still occurs exactly once.
